// File: rtl/beta_exe_stage_pkg.sv
// Shared execute-stage types for the LSU memory controller: op/size encodings,
// controller state and the pending-response record.
package beta_exe_stage_pkg;

    localparam logic       MEM_LOAD_OP     = 1'b0;
    localparam logic       MEM_STORE_OP    = 1'b1;

    localparam logic [1:0] MEM_SIZE_WORD   = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF   = 2'b01;
    localparam logic [1:0] MEM_SIZE_BYTE   = 2'b10;
    localparam logic [1:0] MEM_SIZE_DOUBLE = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WRDY = 2'd1,
        WVLD = 2'd2
    } lsu_state_t;

    // What the response path needs to format a returning beat.
    typedef struct packed {
        logic       op;
        logic [1:0] size;
        logic       uns;
        logic [2:0] off;
    } lsu_pending_t;

    // A 32-bit bus cannot carry a doubleword, so it degrades to a word access.
    function automatic logic [1:0] eff_size(input logic [1:0] size, input int dw);
        return (dw == 32 && size == MEM_SIZE_DOUBLE) ? MEM_SIZE_WORD : size;
    endfunction

    function automatic int unsigned size_bytes(input logic [1:0] size);
        case (size)
            MEM_SIZE_BYTE: return 1;
            MEM_SIZE_HALF: return 2;
            MEM_SIZE_WORD: return 4;
            default:       return 8;
        endcase
    endfunction

endpackage

// File: rtl/beta_lsu_pending_fifo.sv
// In-order queue of issued-but-unanswered requests. Caller guarantees no push
// beyond DEPTH and no pop when empty.
module beta_lsu_pending_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push_i,
    input  T              data_i,
    input  logic          pop_i,
    output T              data_o,
    output logic [CW-1:0] count_o
);

    T              mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) wptr_q <= ptr_inc(wptr_q);
            if (pop_i)  rptr_q <= ptr_inc(rptr_q);
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q] <= data_i;
    end

    assign data_o  = mem_q[rptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/beta_lsu_mem_ctrl.sv
// LSU-to-data-memory controller: registers one request, issues it, tracks it in
// order, formats the response. Optional misaligned trap: BETA_LSU_MISALIGN_TRAP_EN.
module beta_lsu_mem_ctrl
    import beta_exe_stage_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    lsu_req_valid_i,
    output logic                    lsu_req_ready_o,
    input  logic                    lsu_op_i,
    input  logic [1:0]              lsu_size_i,
    input  logic                    lsu_unsigned_i,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr_i,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
    output logic                    lsu_rsp_valid_o,
    output logic [DATA_WIDTH-1:0]   lsu_rdata_o,
    output logic                    lsu_err_o,
    output logic                    lsu_busy_o,
    output logic                    dmem_req_valid_o,
    input  logic                    dmem_req_ready_i,
    output logic                    dmem_we_o,
    output logic [DATA_WIDTH/8-1:0] dmem_be_o,
    output logic [ADDR_WIDTH-1:0]   dmem_addr_o,
    output logic [DATA_WIDTH-1:0]   dmem_wdata_o,
    input  logic                    dmem_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0]   dmem_rdata_i
);

    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NB);
    localparam int CW   = $clog2(MAX_OUTSTANDING + 1);

    lsu_state_t            state_q, state_d;
    lsu_pending_t          req_q, req_d, head;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NB-1:0]         be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CW-1:0]         count;
    logic [CW:0]           count_nxt;
    logic                  push, pop, slot_ok, accept, issue_acc, trap_rsp;

    logic [1:0]            in_size;
    logic [OFFW-1:0]       off_raw, off_mask, in_off;
    logic [7:0]            be_mask;
    logic [DATA_WIDTH-1:0] in_wdata;

    // Decode the incoming request into lane position and replicated data.
    always_comb begin
        in_size  = eff_size(lsu_size_i, DATA_WIDTH);
        off_raw  = lsu_addr_i[OFFW-1:0];
        off_mask = OFFW'(size_bytes(in_size) - 1);
        in_off   = off_raw & ~off_mask;
        case (in_size)
            MEM_SIZE_BYTE: begin be_mask = 8'h01; in_wdata = {NB{lsu_wdata_i[7:0]}}; end
            MEM_SIZE_HALF: begin be_mask = 8'h03; in_wdata = {(NB/2){lsu_wdata_i[15:0]}}; end
            MEM_SIZE_WORD: begin be_mask = 8'h0F; in_wdata = {(NB/4){lsu_wdata_i[31:0]}}; end
            default:       begin be_mask = 8'hFF; in_wdata = lsu_wdata_i; end
        endcase
    end

    assign push      = (state_q == WRDY) && dmem_req_ready_i;
    assign pop       = dmem_rsp_valid_i && (count != '0);
    assign count_nxt = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
    assign slot_ok   = ((state_q == IDLE) || push) && (count_nxt < (CW+1)'(MAX_OUTSTANDING));

`ifdef BETA_LSU_MISALIGN_TRAP_EN
    logic misal, trap_acc, err_q;

    // A misaligned request only enters an empty pipe so its error stays in order.
    assign misal           = (off_raw & off_mask) != '0;
    assign lsu_req_ready_o = rst_n_i && slot_ok &&
                             (!misal || (state_q == IDLE && count == '0));
    assign accept          = lsu_req_valid_i && lsu_req_ready_o;
    assign trap_acc        = accept && misal;
    assign issue_acc       = accept && !misal;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) err_q <= 1'b0;
        else          err_q <= trap_acc;
    end
    assign trap_rsp = err_q;
`else
    assign lsu_req_ready_o = rst_n_i && slot_ok;
    assign accept          = lsu_req_valid_i && lsu_req_ready_o;
    assign issue_acc       = accept;
    assign trap_rsp        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        if (issue_acc) begin
            req_d   = '{op: lsu_op_i, size: in_size, uns: lsu_unsigned_i, off: 3'(in_off)};
            addr_d  = {lsu_addr_i[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
            be_d    = NB'(be_mask) << in_off;
            wdata_d = in_wdata;
        end
        case (state_q)
            IDLE: if (issue_acc) state_d = WRDY;
            WRDY: begin
                if (push) begin
                    if (issue_acc)                                  state_d = WRDY;
                    else if (count_nxt == (CW+1)'(MAX_OUTSTANDING)) state_d = WVLD;
                    else                                            state_d = IDLE;
                end
            end
            WVLD: if (pop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            req_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

    beta_lsu_pending_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .T     (lsu_pending_t)
    ) u_pending (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push),
        .data_i  (req_q),
        .pop_i   (pop),
        .data_o  (head),
        .count_o (count)
    );

    assign dmem_req_valid_o = (state_q == WRDY);
    assign dmem_we_o        = (req_q.op == MEM_STORE_OP);
    assign dmem_be_o        = be_q;
    assign dmem_addr_o      = addr_q;
    assign dmem_wdata_o     = wdata_q;
    assign lsu_busy_o       = (state_q != IDLE) || (count != '0);
    assign lsu_rsp_valid_o  = pop || trap_rsp;
    assign lsu_err_o        = trap_rsp;

    logic [DATA_WIDTH-1:0] rd_sh, ld_mask, ld_ext;
    logic                  ld_sign;

    always_comb begin
        rd_sh = dmem_rdata_i >> {head.off, 3'b000};
        case (head.size)
            MEM_SIZE_BYTE: begin ld_mask = DATA_WIDTH'(8'hFF);         ld_sign = rd_sh[7];  end
            MEM_SIZE_HALF: begin ld_mask = DATA_WIDTH'(16'hFFFF);      ld_sign = rd_sh[15]; end
            MEM_SIZE_WORD: begin ld_mask = DATA_WIDTH'(32'hFFFF_FFFF); ld_sign = rd_sh[31]; end
            default:       begin ld_mask = '1; ld_sign = rd_sh[DATA_WIDTH-1]; end
        endcase
        ld_ext      = (rd_sh & ld_mask) | (~ld_mask & {DATA_WIDTH{ld_sign & ~head.uns}});
        lsu_rdata_o = (pop && head.op == MEM_LOAD_OP) ? ld_ext : '0;
    end

endmodule

// File: tb/tb_beta_lsu_mem_ctrl.sv
// Directed + randomized bench for beta_lsu_mem_ctrl (32-bit bus, 2 outstanding).
// Misaligned-address expectations follow BETA_LSU_MISALIGN_TRAP_EN.
module tb_beta_lsu_mem_ctrl;
    import beta_exe_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_req_valid_i, lsu_req_ready_o, lsu_op_i, lsu_unsigned_i;
    logic [1:0]  lsu_size_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
    logic        lsu_rsp_valid_o, lsu_err_o, lsu_busy_o;
    logic        dmem_req_valid_o, dmem_req_ready_i, dmem_we_o, dmem_rsp_valid_i;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        st;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] w;
    } rec_t;
    rec_t pend_q[$];

    always #5 clk = ~clk;

    beta_lsu_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_OUTSTANDING(2)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .lsu_req_valid_i  (lsu_req_valid_i),
        .lsu_req_ready_o  (lsu_req_ready_o),
        .lsu_op_i         (lsu_op_i),
        .lsu_size_i       (lsu_size_i),
        .lsu_unsigned_i   (lsu_unsigned_i),
        .lsu_addr_i       (lsu_addr_i),
        .lsu_wdata_i      (lsu_wdata_i),
        .lsu_rsp_valid_o  (lsu_rsp_valid_o),
        .lsu_rdata_o      (lsu_rdata_o),
        .lsu_err_o        (lsu_err_o),
        .lsu_busy_o       (lsu_busy_o),
        .dmem_req_valid_o (dmem_req_valid_o),
        .dmem_req_ready_i (dmem_req_ready_i),
        .dmem_we_o        (dmem_we_o),
        .dmem_be_o        (dmem_be_o),
        .dmem_addr_o      (dmem_addr_o),
        .dmem_wdata_o     (dmem_wdata_o),
        .dmem_rsp_valid_i (dmem_rsp_valid_i),
        .dmem_rdata_i     (dmem_rdata_i)
    );

    // Reference model: byte-level arithmetic on a 4-byte bus.
    function automatic int nb_of(input logic [1:0] sz);
        if (sz == MEM_SIZE_BYTE) return 1;
        if (sz == MEM_SIZE_HALF) return 2;
        return 4;
    endfunction

    function automatic int off_of(input logic [1:0] sz, input logic [31:0] a);
        int lane = int'(a % 4);
        return lane - (lane % nb_of(sz));
    endfunction

    function automatic logic [31:0] m_addr(input logic [31:0] a);
        return a - (a % 4);
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        int v = ((1 << nb_of(sz)) - 1) << off_of(sz, a);
        return 4'(v);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] w);
        int     n    = nb_of(sz);
        longint span = longint'(1) << (8 * n);
        longint unit = longint'(w) % span;
        longint res  = 0;
        for (int k = 0; k < 4 / n; k++) res += unit << (8 * n * k);
        return 32'(res);
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic u,
                                           input logic [31:0] a, input logic [31:0] rd);
        int     n    = nb_of(sz);
        longint span = longint'(1) << (8 * n);
        longint v    = (longint'(rd) >> (8 * off_of(sz, a))) % span;
        if (!u && v >= span / 2) v -= span;
        return 32'(v);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input rec_t r);
        int n = 0;
        @(negedge clk);
        lsu_req_valid_i = 1'b1;
        lsu_op_i        = r.st ? MEM_STORE_OP : MEM_LOAD_OP;
        lsu_size_i      = r.sz;
        lsu_unsigned_i  = r.u;
        lsu_addr_i      = r.a;
        lsu_wdata_i     = r.w;
        #1;
        while (!lsu_req_ready_o && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("accept_ready", lsu_req_ready_o, 1'b1);
        @(posedge clk); #1;
        lsu_req_valid_i = 1'b0;
    endtask

    task automatic issue(input rec_t r, input int stall);
        chk("req_valid", dmem_req_valid_o, 1'b1);
        chk("req_addr", dmem_addr_o, m_addr(r.a));
        chk("req_be", dmem_be_o, m_be(r.sz, r.a));
        chk("req_we", dmem_we_o, r.st);
        if (r.st) chk("req_wdata", dmem_wdata_o, m_wdata(r.sz, r.w));
        repeat (stall) begin
            @(negedge clk);
            chk("stall_valid", dmem_req_valid_o, 1'b1);
            chk("stall_addr", dmem_addr_o, m_addr(r.a));
            chk("stall_be", dmem_be_o, m_be(r.sz, r.a));
            chk("stall_wdata", dmem_wdata_o, m_wdata(r.sz, r.w));
        end
        dmem_req_ready_i = 1'b1;
        @(posedge clk); #1;
        dmem_req_ready_i = 1'b0;
        pend_q.push_back(r);
    endtask

    task automatic respond_exp(input logic [31:0] rd, input logic [31:0] exp);
        void'(pend_q.pop_front());
        dmem_rsp_valid_i = 1'b1;
        dmem_rdata_i     = rd;
        #1;
        chk("rsp_valid", lsu_rsp_valid_o, 1'b1);
        chk("rsp_rdata", lsu_rdata_o, exp);
        chk("rsp_err", lsu_err_o, 1'b0);
        @(posedge clk); #1;
        dmem_rsp_valid_i = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rd);
        rec_t r = pend_q[0];
        respond_exp(rd, r.st ? 32'h0 : m_load(r.sz, r.u, r.a, rd));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rec_t r, ra, rb, rc;
        logic [31:0] rd;

        rst_n = 1'b0;
        lsu_req_valid_i = 1'b1; lsu_op_i = 1'b0; lsu_size_i = 2'b00; lsu_unsigned_i = 1'b0;
        lsu_addr_i = 32'h4; lsu_wdata_i = 32'h0;
        dmem_req_ready_i = 1'b1; dmem_rsp_valid_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
        #12;
        chk("rst_ready", lsu_req_ready_o, 1'b0);
        chk("rst_rsp_valid", lsu_rsp_valid_o, 1'b0);
        chk("rst_req_valid", dmem_req_valid_o, 1'b0);
        chk("rst_busy", lsu_busy_o, 1'b0);
        chk("rst_rdata", lsu_rdata_o, 32'h0);
        chk("rst_be", dmem_be_o, 4'h0);
        lsu_req_valid_i = 1'b0; dmem_req_ready_i = 1'b0; dmem_rsp_valid_i = 1'b0;
        @(negedge clk); rst_n = 1'b1; #1;
        chk("idle_ready", lsu_req_ready_o, 1'b1);
        chk("idle_busy", lsu_busy_o, 1'b0);

        // Sign/zero-extended byte loads from the top lane
        r = '{1'b0, MEM_SIZE_BYTE, 1'b0, 32'h3, 32'h0};
        send(r);
        chk("byte_be", dmem_be_o, 4'b1000);
        issue(r, 0);
        respond_exp(32'h80FF_FFFF, 32'hFFFF_FF80);
        r.u = 1'b1;
        send(r); issue(r, 0);
        respond_exp(32'h80FF_FFFF, 32'h0000_0080);

        // Half store lane placement
        r = '{1'b1, MEM_SIZE_HALF, 1'b0, 32'h2, 32'h0000_1234};
        send(r);
        chk("half_be", dmem_be_o, 4'b1100);
        chk("half_wdata", dmem_wdata_o, 32'h1234_1234);
        chk("half_addr", dmem_addr_o, 32'h0);
        issue(r, 0);
        respond_exp(32'h5555_5555, 32'h0);

        // Memory stalls for 5 cycles
        r = '{1'b1, MEM_SIZE_BYTE, 1'b0, 32'h101, 32'h0000_00A5};
        send(r); issue(r, 5); respond(32'h0);

        // Misaligned word load
        r = '{1'b0, MEM_SIZE_WORD, 1'b0, 32'h2, 32'h0};
`ifdef BETA_LSU_MISALIGN_TRAP_EN
        send(r);
        chk("trap_no_issue", dmem_req_valid_o, 1'b0);
        chk("trap_rsp_valid", lsu_rsp_valid_o, 1'b1);
        chk("trap_err", lsu_err_o, 1'b1);
        @(posedge clk); #1;
        chk("trap_rsp_once", lsu_rsp_valid_o, 1'b0);
        chk("trap_no_issue2", dmem_req_valid_o, 1'b0);
`else
        send(r);
        chk("misal_addr", dmem_addr_o, 32'h0);
        chk("misal_be", dmem_be_o, 4'b1111);
        issue(r, 0);
        respond_exp(32'h1122_3344, 32'h1122_3344);
`endif

        // Back-to-back requests against the outstanding limit
        ra = '{1'b0, MEM_SIZE_WORD, 1'b0, 32'h40, 32'h0};
        rb = '{1'b0, MEM_SIZE_HALF, 1'b1, 32'h52, 32'h0};
        rc = '{1'b1, MEM_SIZE_WORD, 1'b0, 32'h60, 32'hCAFE_BABE};
        @(negedge clk);
        dmem_req_ready_i = 1'b1;
        lsu_req_valid_i = 1'b1; lsu_op_i = MEM_LOAD_OP; lsu_size_i = ra.sz;
        lsu_unsigned_i = ra.u; lsu_addr_i = ra.a; lsu_wdata_i = ra.w;
        #1; chk("bb_rdy_a", lsu_req_ready_o, 1'b1);
        @(negedge clk);
        chk("bb_issue_a", dmem_req_valid_o, 1'b1);
        chk("bb_addr_a", dmem_addr_o, 32'h40);
        chk("bb_rdy_b", lsu_req_ready_o, 1'b1);
        lsu_size_i = rb.sz; lsu_unsigned_i = rb.u; lsu_addr_i = rb.a;
        @(negedge clk);
        chk("bb_issue_b", dmem_req_valid_o, 1'b1);
        chk("bb_addr_b", dmem_addr_o, 32'h50);
        chk("bb_rdy_c_blocked", lsu_req_ready_o, 1'b0);
        lsu_op_i = MEM_STORE_OP; lsu_size_i = rc.sz; lsu_unsigned_i = rc.u;
        lsu_addr_i = rc.a; lsu_wdata_i = rc.w;
        pend_q.push_back(ra); pend_q.push_back(rb);
        @(negedge clk);
        chk("bb_full_no_issue", dmem_req_valid_o, 1'b0);
        chk("bb_full_ready", lsu_req_ready_o, 1'b0);
        chk("bb_full_busy", lsu_busy_o, 1'b1);
        repeat (2) @(negedge clk);
        chk("bb_full_ready_hold", lsu_req_ready_o, 1'b0);
        rd = 32'hDEAD_BEEF;
        dmem_rsp_valid_i = 1'b1; dmem_rdata_i = rd; #1;
        chk("bb_rsp_a_valid", lsu_rsp_valid_o, 1'b1);
        chk("bb_rsp_a_data", lsu_rdata_o, m_load(ra.sz, ra.u, ra.a, rd));
        void'(pend_q.pop_front());
        @(negedge clk);
        dmem_rsp_valid_i = 1'b0; #1;
        chk("bb_rdy_c", lsu_req_ready_o, 1'b1);
        @(posedge clk); #1;
        lsu_req_valid_i = 1'b0;
        chk("bb_issue_c", dmem_req_valid_o, 1'b1);
        chk("bb_addr_c", dmem_addr_o, 32'h60);
        chk("bb_we_c", dmem_we_o, 1'b1);
        chk("bb_wdata_c", dmem_wdata_o, 32'hCAFE_BABE);
        @(posedge clk); #1;
        dmem_req_ready_i = 1'b0;
        pend_q.push_back(rc);
        respond(32'h8765_4321);
        respond(32'h0);
        chk("bb_drained_busy", lsu_busy_o, 1'b0);

        // Response with nothing pending
        dmem_rsp_valid_i = 1'b1; dmem_rdata_i = 32'h1234_5678; #1;
        chk("spurious_rsp", lsu_rsp_valid_o, 1'b0);
        @(posedge clk); #1;
        dmem_rsp_valid_i = 1'b0;

        // Reset while two requests are outstanding
        r = '{1'b0, MEM_SIZE_WORD, 1'b0, 32'h80, 32'h0};
        send(r); issue(r, 0);
        r.a = 32'h84;
        send(r); issue(r, 0);
        chk("mid_busy", lsu_busy_o, 1'b1);
        #2; rst_n = 1'b0; #1;
        chk("mid_rst_busy", lsu_busy_o, 1'b0);
        chk("mid_rst_ready", lsu_req_ready_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        pend_q.delete();
        dmem_rsp_valid_i = 1'b1; dmem_rdata_i = 32'hAAAA_AAAA; #1;
        chk("post_rst_rsp", lsu_rsp_valid_o, 1'b0);
        chk("post_rst_rdata", lsu_rdata_o, 32'h0);
        @(posedge clk); #1;
        dmem_rsp_valid_i = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            r.st = 1'($urandom_range(0, 1));
            r.sz = 2'($urandom_range(0, 3));
            r.u  = 1'($urandom_range(0, 1));
            r.a  = $urandom_range(0, 255);
            r.w  = $urandom;
`ifdef BETA_LSU_MISALIGN_TRAP_EN
            r.a  = r.a - (r.a % nb_of(r.sz));
`endif
            send(r);
            issue(r, $urandom_range(0, 2));
            if (pend_q.size() == 2 || $urandom_range(0, 1) == 1) respond($urandom);
        end
        while (pend_q.size() > 0) respond($urandom);
        chk("final_busy", lsu_busy_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/beta_lsu_mem_ctrl.md
BETA_LSU_MEM_CTRL -- requirements
Module: beta_lsu_mem_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data bus width; legal values are 32 and 64.
REQ-002 Parameter ADDR_WIDTH, default 32, SHALL set the byte-address width.
REQ-003 Parameter MAX_OUTSTANDING, default 2, SHALL set the accepted-but-unanswered request limit; legal values are powers of two from 1 to 8.
REQ-004 Port list (name, direction, width, meaning) SHALL be as follows; the block uses one clock, and reset is asynchronous and active-low.
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- lsu_req_valid_i  in  1  execute-stage request valid.
- lsu_req_ready_o  out  1  request accepted this cycle.
- lsu_op_i  in  1  MEM_LOAD_OP or MEM_STORE_OP.
- lsu_size_i  in  2  MEM_SIZE_WORD, MEM_SIZE_HALF, MEM_SIZE_BYTE or MEM_SIZE_DOUBLE.
- lsu_unsigned_i  in  1  zero-extend the load.
- lsu_addr_i  in  ADDR_WIDTH  byte address.
- lsu_wdata_i  in  DATA_WIDTH  store data, right-aligned.
- lsu_rsp_valid_o  out  1  response valid, one cycle.
- lsu_rdata_o  out  DATA_WIDTH  extended load data; 0 for stores.
- lsu_err_o  out  1  misaligned request response.
- lsu_busy_o  out  1  state not IDLE or pending count nonzero.
- dmem_req_valid_o  out  1  memory request valid.
- dmem_req_ready_i  in  1  memory accepts the request.
- dmem_we_o  out  1  write enable.
- dmem_be_o  out  DATA_WIDTH/8  byte enables.
- dmem_addr_o  out  ADDR_WIDTH  address aligned to DATA_WIDTH/8 bytes.
- dmem_wdata_o  out  DATA_WIDTH  lane-positioned store data.
- dmem_rsp_valid_i  in  1  memory response; one response per request, loads and stores, in order.
- dmem_rdata_i  in  DATA_WIDTH  raw read data.

Function
REQ-005 The FSM SHALL have exactly three states: IDLE (no request held), WRDY (request held, waiting on dmem_req_ready_i) and WVLD (pending queue full, waiting on dmem_rsp_valid_i).
REQ-006 lsu_req_ready_o SHALL be asserted when (state is IDLE, or state is WRDY and dmem_req_ready_i is high) and the pending count after this cycle's push and pop is below MAX_OUTSTANDING.
REQ-007 An accepted request SHALL be registered, and dmem_req_valid_o SHALL rise on the following cycle (one-cycle issue latency) with state WRDY.
REQ-008 In WRDY, all dmem_* request outputs SHALL stay stable until dmem_req_ready_i is sampled high.
REQ-009 A request/ready handshake SHALL push {op, size, unsigned, byte offset} into the pending queue.
REQ-010 The next state after a handshake SHALL be WRDY if a new request is accepted in the same cycle, else WVLD if the queue is full, else IDLE.
REQ-011 In WVLD, a dmem_rsp_valid_i pop SHALL move the FSM to IDLE.
REQ-012 A simultaneous push and pop SHALL leave the pending count unchanged.
REQ-013 Each dmem_rsp_valid_i SHALL produce lsu_rsp_valid_o in the same cycle (combinational path, no back-pressure) and pop the queue head.
REQ-014 dmem_rsp_valid_i with an empty queue SHALL be ignored.
REQ-015 Byte enables SHALL be the size mask shifted by addr[log2(DATA_WIDTH/8)-1:0]; store data SHALL be replicated across lanes.
REQ-016 Load data SHALL be shifted right by 8*offset, masked to the access size, and sign-extended unless unsigned is set.
REQ-017 MEM_SIZE_DOUBLE with DATA_WIDTH=32 SHALL be treated as MEM_SIZE_WORD.

Reset
REQ-018 Asserting rst_n_i low SHALL immediately force the state to IDLE, empty the queue, and drive every output to 0.
REQ-019 Reset mid-transaction SHALL drop all pending entries, so that responses arriving after reset fall under REQ-014.

Configuration
REQ-020 With BETA_LSU_MISALIGN_TRAP_EN defined, a request whose address is not size-aligned SHALL be accepted only when the pending count is 0, SHALL never be issued to memory, and SHALL produce lsu_rsp_valid_o=1 with lsu_err_o=1 one cycle after acceptance.
REQ-021 Without BETA_LSU_MISALIGN_TRAP_EN, the address SHALL be aligned down to the access size and lsu_err_o SHALL be tied to 0.

Structure
REQ-022 beta_exe_stage_pkg SHALL gain MEM_SIZE_DOUBLE=2'b11, an lsu_state_t enum (IDLE/WRDY/WVLD) and an lsu_pending_t packed struct.
REQ-023 The pending queue SHALL be a sub-module named beta_lsu_pending_fifo, parametrised by depth and entry type.

Verification
REQ-024 Byte load from 0x3 with dmem_rdata_i=0x80FF_FFFF -> lsu_rdata_o=0xFFFF_FF80; with unsigned set -> 0x0000_0080.
REQ-025 Half store of 0x1234 to 0x2 -> dmem_be_o=4'b1100, dmem_wdata_o=0x1234_1234, dmem_addr_o=0x0.
REQ-026 MAX_OUTSTANDING=2, dmem_req_ready_i held high, no responses, three back-to-back requests -> two issued, state WVLD, lsu_req_ready_o=0; one response -> third request accepted.
REQ-027 dmem_req_ready_i low for 5 cycles -> dmem_addr_o, dmem_be_o and dmem_wdata_o stable for all 5 cycles.
REQ-028 With the macro defined, word load from 0x2 -> no dmem_req_valid_o, and lsu_err_o=1 on the cycle after acceptance.
REQ-029 rst_n_i pulsed low while 2 requests are pending, then dmem_rsp_valid_i asserted -> lsu_rsp_valid_o stays 0.
